// File: rtl/video_capture_pkg.sv
// Shared types, constants and helpers for the video capture block.
package video_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [7:0]  ALPHA    = 8'hFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Widen a channel held in the LSBs of v to 8 bits by repeating its bits MSB first.
    function automatic logic [7:0] expand_chan(input logic [7:0] v, input int unsigned bits);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[3'(7 - i)] = v[3'(bits - 1 - (i % bits))];
        end
        return r;
    endfunction

    // Advance a CRC-16/CCITT over one 24-bit pixel, MSB first.
    function automatic logic [15:0] crc16_px(input logic [15:0] crc, input logic [23:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ d[5'(i)];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/video_capture_if.sv
// Pixel output stream: ARGB word plus its coordinates, valid/ready handshake.
interface video_capture_if #(
    parameter int unsigned X_BITS = 10,
    parameter int unsigned Y_BITS = 10
) ();
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       out_data_o;
    logic [X_BITS-1:0] out_x_o;
    logic [Y_BITS-1:0] out_y_o;

    modport master (output out_valid_o, out_data_o, out_x_o, out_y_o, input out_ready_i);
    modport slave  (input out_valid_o, out_data_o, out_x_o, out_y_o, output out_ready_i);
endinterface

// File: rtl/video_capture_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only with a same-cycle pop.
module video_capture_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_c = (wr_q == rd_q);
    assign full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop & ~empty_c;
    assign do_push = push & (~full_c | do_pop);
    assign rdata_c = mem[rd_q[AW-1:0]];

    // Read/write pointers with wrap bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/video_capture.sv
// Video frame capture into an ARGB8888 stream with coordinates.
// Optional frame CRC enabled by defining VIDEO_CAPTURE_CRC_EN.
module video_capture
    import video_capture_pkg::*;
#(
    parameter int unsigned COLOR_BITS      = 3,
    parameter int unsigned X_BITS          = 10,
    parameter int unsigned Y_BITS          = 10,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_ce,
    input  logic [3*COLOR_BITS-1:0] rgb_i,
    input  logic                    hsync_i,
    input  logic                    vsync_i,
    input  logic                    hblank_i,
    input  logic                    vblank_i,
    input  logic                    enable_i,
    video_capture_if.master         vid,
    output logic                    frame_done_o,
    output logic [15:0]             frame_count_o,
    output logic                    overflow_o,
    output logic [15:0]             frame_crc_o
);
    localparam int unsigned FW = 32 + X_BITS + Y_BITS;

    state_t            state_q, state_d;
    logic              vs_act, vs_act_q, vs_edge;
    logic              hb_q, hb_rise;
    logic              en_q, en_rise;
    logic              line_px_q;
    logic [X_BITS-1:0] x_q;
    logic [Y_BITS-1:0] y_q;
    logic [7:0]        r8, g8, b8;
    logic              push_c, pop_c, accept_c, full_c, empty_c;
    logic [FW-1:0]     wdata_c, rdata_c;
    logic              unused_hsync;

    // Horizontal sync carries no information the capture needs; blanking drives line control.
    assign unused_hsync = hsync_i;

    assign vs_act  = (SYNC_ACTIVE_LOW != 0) ? ~vsync_i : vsync_i;
    assign vs_edge = pix_ce & vs_act & ~vs_act_q;
    assign hb_rise = pix_ce & hblank_i & ~hb_q;
    assign en_rise = enable_i & ~en_q;

    assign r8 = expand_chan(8'(rgb_i[COLOR_BITS-1:0]), COLOR_BITS);
    assign g8 = expand_chan(8'(rgb_i[2*COLOR_BITS-1:COLOR_BITS]), COLOR_BITS);
    assign b8 = expand_chan(8'(rgb_i[3*COLOR_BITS-1:2*COLOR_BITS]), COLOR_BITS);

    // A frame-ending vsync edge never doubles as a pixel.
    assign push_c   = (state_q == ST_CAPTURE) & pix_ce & ~hblank_i & ~vblank_i & ~vs_edge;
    assign wdata_c  = {ALPHA, r8, g8, b8, x_q, y_q};
    assign pop_c    = ~empty_c & vid.out_ready_i;
    assign accept_c = push_c & (~full_c | pop_c);

    assign vid.out_valid_o = ~empty_c;
    assign vid.out_data_o  = rdata_c[FW-1 -: 32];
    assign vid.out_x_o     = rdata_c[Y_BITS +: X_BITS];
    assign vid.out_y_o     = rdata_c[Y_BITS-1:0];

    video_capture_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_c),
        .wdata   (wdata_c),
        .pop     (pop_c),
        .rdata_c (rdata_c),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Sync/blank history (pixel-rate) and enable history (clock-rate).
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_act_q <= 1'b0;
            hb_q     <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            en_q <= enable_i;
            if (pix_ce) begin
                vs_act_q <= vs_act;
                hb_q     <= hblank_i;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (enable_i) state_d = ST_WAIT_VS;
            ST_WAIT_VS: begin
                if (!enable_i)    state_d = ST_IDLE;
                else if (vs_edge) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: if (vs_edge) state_d = enable_i ? ST_CAPTURE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pixel coordinates, line tracking and frame completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            line_px_q     <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_count_o <= '0;
        end else begin
            frame_done_o <= 1'b0;
            if (state_q == ST_WAIT_VS && vs_edge) begin
                x_q       <= '0;
                y_q       <= '0;
                line_px_q <= 1'b0;
            end else if (state_q == ST_CAPTURE) begin
                if (vs_edge) begin
                    frame_done_o  <= 1'b1;
                    frame_count_o <= frame_count_o + 16'd1;
                    x_q           <= '0;
                    y_q           <= '0;
                    line_px_q     <= 1'b0;
                end else if (push_c) begin
                    if (x_q != '1) x_q <= x_q + X_BITS'(1);
                    line_px_q <= 1'b1;
                end else if (hb_rise && line_px_q) begin
                    x_q <= '0;
                    if (y_q != '1) y_q <= y_q + Y_BITS'(1);
                    line_px_q <= 1'b0;
                end
            end
        end
    end

    // Sticky drop flag, cleared when capture is re-armed.
    always_ff @(posedge clk) begin
        if (reset)                          overflow_o <= 1'b0;
        else if (en_rise)                   overflow_o <= 1'b0;
        else if (push_c && full_c && !pop_c) overflow_o <= 1'b1;
    end

`ifdef VIDEO_CAPTURE_CRC_EN
    logic [15:0] crc_q;

    // Running CRC over accepted pixels, published at frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q       <= CRC_INIT;
            frame_crc_o <= '0;
        end else if (state_q == ST_WAIT_VS && vs_edge) begin
            crc_q <= CRC_INIT;
        end else if (state_q == ST_CAPTURE) begin
            if (vs_edge) begin
                frame_crc_o <= crc_q;
                crc_q       <= CRC_INIT;
            end else if (accept_c) begin
                crc_q <= crc16_px(crc_q, {r8, g8, b8});
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept_c;
    assign frame_crc_o   = '0;
`endif

endmodule

// File: tb/tb_video_capture.sv
// Directed testbench for video_capture (COLOR_BITS=3, FIFO_DEPTH=16, active-low syncs).
module tb_video_capture;
    import video_capture_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_ce;
    logic [8:0]  rgb_i;
    logic        hsync_i, vsync_i, hblank_i, vblank_i, enable_i;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        overflow;
    logic [15:0] frame_crc;

    int errors = 0;
    int checks = 0;

    logic [31:0] q_data[$];
    logic [9:0]  q_x[$];
    logic [9:0]  q_y[$];
    int          fd_cnt = 0;

    video_capture_if #(.X_BITS(10), .Y_BITS(10)) vid ();

    video_capture #(
        .COLOR_BITS(3), .X_BITS(10), .Y_BITS(10), .FIFO_DEPTH(16), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pix_ce        (pix_ce),
        .rgb_i         (rgb_i),
        .hsync_i       (hsync_i),
        .vsync_i       (vsync_i),
        .hblank_i      (hblank_i),
        .vblank_i      (vblank_i),
        .enable_i      (enable_i),
        .vid           (vid),
        .frame_done_o  (frame_done),
        .frame_count_o (frame_count),
        .overflow_o    (overflow),
        .frame_crc_o   (frame_crc)
    );

    always #5 clk = ~clk;

    // Record every word consumed at the next rising edge, and every frame_done pulse.
    always @(negedge clk) begin
        if (vid.out_valid_o && vid.out_ready_i) begin
            q_data.push_back(vid.out_data_o);
            q_x.push_back(vid.out_x_o);
            q_y.push_back(vid.out_y_o);
        end
        if (frame_done) fd_cnt++;
    end

    function automatic logic [15:0] golden_crc(input logic [23:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic [8:0] rgb, input logic hb, input logic vb, input logic vs);
        pix_ce = ce; rgb_i = rgb; hblank_i = hb; vblank_i = vb; vsync_i = vs;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic sync_pulse();
        drive(1'b1, 9'h000, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 9'h000, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 9'h000, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic line(input int n, input logic [8:0] rgb);
        for (int i = 0; i < n; i++) drive(1'b1, rgb, 1'b0, 1'b0, 1'b1);
        drive(1'b1, rgb, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1; pix_ce = 1'b0; rgb_i = '0; hsync_i = 1'b1; vsync_i = 1'b1;
        hblank_i = 1'b0; vblank_i = 1'b0; enable_i = 1'b0; vid.out_ready_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (vid.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", vid.out_valid_o); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
        checks++; if (frame_crc !== 16'h0000) begin errors++; $display("FAIL reset_crc got=%h exp=0000", frame_crc); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_wait_abort();
        do_reset();
        enable_i = 1'b1;
        tick();
        checks++; if (dut.state_q !== ST_WAIT_VS) begin errors++; $display("FAIL arm_state got=%0d exp=%0d", dut.state_q, ST_WAIT_VS); end
        enable_i = 1'b0;
        tick();
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL disarm_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_basic_frame();
        int qb, fb, n;
        do_reset();
        enable_i = 1'b1; vid.out_ready_i = 1'b1;
        qb = q_data.size(); fb = fd_cnt;
        sync_pulse();
        line(4, 9'h1FF);
        line(4, 9'h1FF);
        sync_pulse();
        idle(5);
        n = q_data.size() - qb;
        checks++; if (n !== 8) begin errors++; $display("FAIL basic_words got=%0d exp=8", n); end
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                checks++; if (q_data[qb+i] !== 32'hFFFFFFFF) begin errors++; $display("FAIL basic_data[%0d] got=%h exp=ffffffff", i, q_data[qb+i]); end
                checks++; if (q_x[qb+i] !== 10'(i % 4)) begin errors++; $display("FAIL basic_x[%0d] got=%0d exp=%0d", i, q_x[qb+i], i % 4); end
                checks++; if (q_y[qb+i] !== 10'(i / 4)) begin errors++; $display("FAIL basic_y[%0d] got=%0d exp=%0d", i, q_y[qb+i], i / 4); end
            end
        end
        checks++; if (fd_cnt - fb !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", fd_cnt - fb); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", frame_count); end
    endtask

    task automatic test_color();
        int qb, n;
        do_reset();
        enable_i = 1'b1; vid.out_ready_i = 1'b1;
        qb = q_data.size();
        sync_pulse();
        drive(1'b1, 9'h015, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 9'h0F1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 9'h000, 1'b1, 1'b0, 1'b1);
        sync_pulse();
        idle(4);
        n = q_data.size() - qb;
        checks++; if (n !== 2) begin errors++; $display("FAIL color_words got=%0d exp=2", n); end
        if (n >= 2) begin
            checks++; if (q_data[qb] !== 32'hFFB64900) begin errors++; $display("FAIL color_data0 got=%h exp=ffb64900", q_data[qb]); end
            checks++; if (q_data[qb+1] !== 32'hFF24DB6D) begin errors++; $display("FAIL color_data1 got=%h exp=ff24db6d", q_data[qb+1]); end
            checks++; if (q_x[qb+1] !== 10'd1) begin errors++; $display("FAIL color_x1 got=%0d exp=1", q_x[qb+1]); end
        end
    endtask

    task automatic test_overflow();
        int qb, n;
        do_reset();
        enable_i = 1'b1; vid.out_ready_i = 1'b0;
        qb = q_data.size();
        sync_pulse();
        for (int i = 0; i < 20; i++) drive(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b1);
        idle(2);
        checks++; if (vid.out_valid_o !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b exp=1", vid.out_valid_o); end
        checks++; if (vid.out_x_o !== 10'd0) begin errors++; $display("FAIL ovf_hold_x got=%0d exp=0", vid.out_x_o); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        vid.out_ready_i = 1'b1;
        idle(20);
        n = q_data.size() - qb;
        checks++; if (n !== 16) begin errors++; $display("FAIL ovf_words got=%0d exp=16", n); end
        if (n > 0) begin
            checks++; if (q_x[q_x.size()-1] !== 10'd15) begin errors++; $display("FAIL ovf_last_x got=%0d exp=15", q_x[q_x.size()-1]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        enable_i = 1'b0;
        idle(2);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky_disarm got=%b exp=1", overflow); end
        enable_i = 1'b1;
        idle(1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_back_to_back();
        int qb, fb, n;
        do_reset();
        enable_i = 1'b1; vid.out_ready_i = 1'b0;
        qb = q_data.size(); fb = fd_cnt;
        sync_pulse();
        for (int i = 0; i < 16; i++) drive(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf got=%b exp=0", overflow); end
        vid.out_ready_i = 1'b1;
        drive(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b1);
        vid.out_ready_i = 1'b0;
        idle(2);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf got=%b exp=0", overflow); end
        vid.out_ready_i = 1'b1;
        idle(20);
        n = q_data.size() - qb;
        checks++; if (n !== 17) begin errors++; $display("FAIL full_pushpop_words got=%0d exp=17", n); end
        if (n > 0) begin
            checks++; if (q_x[q_x.size()-1] !== 10'd16) begin errors++; $display("FAIL full_pushpop_last_x got=%0d exp=16", q_x[q_x.size()-1]); end
        end
        // Two consecutive frames: coordinates restart and the count advances twice.
        qb = q_data.size();
        drive(1'b1, 9'h000, 1'b1, 1'b0, 1'b1);
        sync_pulse();
        line(2, 9'h1C0);
        sync_pulse();
        idle(4);
        n = q_data.size() - qb;
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_words got=%0d exp=2", n); end
        if (n >= 2) begin
            checks++; if (q_data[qb] !== 32'hFF0000FF) begin errors++; $display("FAIL b2b_data got=%h exp=ff0000ff", q_data[qb]); end
            checks++; if (q_x[qb] !== 10'd0 || q_y[qb] !== 10'd0) begin errors++; $display("FAIL b2b_coord got=(%0d,%0d) exp=(0,0)", q_x[qb], q_y[qb]); end
        end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", frame_count); end
        checks++; if (fd_cnt - fb !== 2) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=2", fd_cnt - fb); end
    endtask

    task automatic test_reset_mid_line();
        int fb;
        do_reset();
        enable_i = 1'b1; vid.out_ready_i = 1'b0;
        fb = fd_cnt;
        sync_pulse();
        for (int i = 0; i < 3; i++) drive(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        checks++; if (vid.out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", vid.out_valid_o); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL midrst_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", frame_count); end
        reset = 1'b0;
        sync_pulse();
        idle(3);
        checks++; if (fd_cnt - fb !== 0) begin errors++; $display("FAIL midrst_done_pulses got=%0d exp=0", fd_cnt - fb); end
        checks++; if (vid.out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_flushed got=%b exp=0", vid.out_valid_o); end
    endtask

    task automatic test_crc();
        logic [15:0] exp_crc;
`ifdef VIDEO_CAPTURE_CRC_EN
        exp_crc = golden_crc(24'h000000);
`else
        exp_crc = 16'h0000;
`endif
        do_reset();
        enable_i = 1'b1; vid.out_ready_i = 1'b1;
        sync_pulse();
        line(1, 9'h000);
        sync_pulse();
        idle(3);
        checks++; if (frame_crc !== exp_crc) begin errors++; $display("FAIL crc_frame got=%h exp=%h", frame_crc, exp_crc); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL crc_count got=%0d exp=1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_wait_abort();
        test_basic_frame();
        test_color();
        test_overflow();
        test_back_to_back();
        test_reset_mid_line();
        test_crc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
